clk_div_gen: RTL

- Parametrised, runtime-programmable successor to the fixed divide-by-2 clock generator.
- Produces from the system clock:
  - a registered divided-clock level, `clk_out` (high for ceil(D/2) cycles, low for floor(D/2) cycles);
  - a one-cycle `tick` enable for downstream logic (game-tick, paddle and ball update, VGA sub-rates).
- The divisor can be changed glitch-free at run time; a new value takes effect only at a period boundary.

---
 rtl/clk_div_if.sv | 22 ++
 rtl/clk_div_gen.sv | 84 ++++++++
 2 files changed

// File: rtl/clk_div_if.sv
// Control/status bundle between a clk_div_gen instance and its user.
// The master drives the enable and divisor-load request; the slave is the divider.
interface clk_div_if #(parameter int WIDTH = 8);
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             load_ack;
    logic             load_err;
    logic [WIDTH-1:0] div_cur;

    modport master (
        output en, div_in, div_load,
        input  clk_out, tick, load_ack, load_err, div_cur
    );

    modport slave (
        input  en, div_in, div_load,
        output clk_out, tick, load_ack, load_err, div_cur
    );
endinterface

// File: rtl/clk_div_gen.sv
// Runtime-programmable clock divider: registered divided level plus a one-cycle tick
// in the last cycle of each period. New divisors apply only at a period boundary.
module clk_div_gen #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic     clk,
    input  logic     rst,
    clk_div_if.slave bus
);
    generate
        if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** WIDTH) - 1) begin : g_bad_default
            $error("clk_div_gen: DEFAULT_DIV out of range");
        end
    endgenerate

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_cur;
    logic             pend;
    logic [WIDTH-1:0] pend_val;
    logic             clk_out;
    logic             tick;
    logic             load_ack;
    logic             load_err;

    logic             wrap;
    logic [WIDTH:0]   high_len;
    logic             load_ok;

    // One extra bit so D = 2^WIDTH-1 does not overflow when rounding up.
    assign high_len = ({1'b0, div_cur} + (WIDTH+1)'(1)) >> 1;
    assign wrap     = (cnt == div_cur - WIDTH'(1));
    assign load_ok  = bus.div_load && (bus.div_in >= WIDTH'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            div_cur  <= WIDTH'(DEFAULT_DIV);
            pend     <= 1'b0;
            pend_val <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            load_ack <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= 1'b0;
            load_ack <= 1'b0;
            load_err <= bus.div_load && !load_ok;

            if (bus.en) begin
                clk_out <= ({1'b0, cnt} < high_len);
                if (wrap) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    if (pend) begin
                        div_cur  <= pend_val;
                        pend     <= 1'b0;
                        load_ack <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
            end else if (pend) begin
                // Idle divider: nothing to glitch, so apply right away and restart the period.
                cnt      <= '0;
                div_cur  <= pend_val;
                pend     <= 1'b0;
                load_ack <= 1'b1;
            end

            // A request arriving on the apply edge waits for the next boundary.
            if (load_ok) begin
                pend     <= 1'b1;
                pend_val <= bus.div_in;
            end
        end
    end

    assign bus.clk_out  = clk_out;
    assign bus.tick     = tick;
    assign bus.load_ack = load_ack;
    assign bus.load_err = load_err;
    assign bus.div_cur  = div_cur;
endmodule
